// File: rtl/io_mux_pkg.sv
// Shared definitions for the pad-mux function sequencer: function bit layout,
// sequencer states and a constant helper for sizing the shared wait counter.
package io_mux_pkg;

  localparam int N_FUNC   = 13;
  localparam int FN_IRQ   = 0;
  localparam int FN_UART1 = 1;
  localparam int FN_SPI0  = 4;
  localparam int FN_PWM0  = 5;
  localparam int N_UART   = 3;
  localparam int N_PWM    = 8;

  typedef logic [N_FUNC-1:0] fmask_t;

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    DISABLE,
    ENABLE,
    DONE
  } seq_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/io_seq_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// A wait of N cycles loads N-1 on state entry and leaves when expired.
module io_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/io_function_sequencer.sv
// Applies a new peripheral function mask to the pad mux as quiesce -> disable
// (guard gap) -> enable (settle), so GPIO and peripheral never co-own a pad.
module io_function_sequencer
  import io_mux_pkg::*;
#(
  parameter int GUARD_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int IDLE_TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [N_FUNC-1:0] req_mask,
  input  logic [N_FUNC-1:0] periph_idle,
  output logic [N_FUNC-1:0] active_mask,
  output logic              irq_en,
  output logic [N_UART-1:0] uart_en,
  output logic [0:0]        spi_en,
  output logic [N_PWM-1:0]  pwm_en,
  output logic              busy,
  output logic              done,
  output logic              done_timeout
);

  localparam int CNT_W = $clog2(max3(GUARD_CYCLES, SETTLE_CYCLES, IDLE_TIMEOUT)) + 1;

  seq_state_e state_q, state_d;
  fmask_t     active_q, active_d;
  fmask_t     dis_q, dis_d;
  fmask_t     ena_q, ena_d;
  logic       tmo_q, tmo_d;

  fmask_t     dis_new, ena_new;
  logic       accept;
  logic       tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic       tmr_exp;

  assign accept  = req_valid && (state_q == IDLE);
  assign dis_new = active_q & ~req_mask;
  assign ena_new = req_mask & ~active_q;

  // Mask updates happen on the same edge that enters DISABLE/ENABLE, so the
  // applied mask changes exactly when the corresponding wait begins.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    dis_d    = dis_q;
    ena_d    = ena_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          dis_d = dis_new;
          ena_d = ena_new;
          tmo_d = 1'b0;
          if (dis_new != '0) begin
            state_d = QUIESCE;
          end else if (ena_new != '0) begin
            state_d  = ENABLE;
            active_d = active_q | ena_new;
          end else begin
            state_d = DONE;
          end
        end
      end
      QUIESCE: begin
        if ((periph_idle & dis_q) == dis_q) begin
          state_d  = DISABLE;
          active_d = active_q & ~dis_q;
        end else if (tmr_exp) begin
          state_d  = DISABLE;
          active_d = active_q & ~dis_q;
          tmo_d    = 1'b1;
        end
      end
      DISABLE: begin
        if (tmr_exp) begin
          if (ena_q != '0) begin
            state_d  = ENABLE;
            active_d = active_q | ena_q;
          end else begin
            state_d = DONE;
          end
        end
      end
      ENABLE: begin
        if (tmr_exp) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every state entry reloads the shared counter with that state's dwell - 1.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    case (state_d)
      QUIESCE: tmr_val = CNT_W'(IDLE_TIMEOUT - 1);
      DISABLE: tmr_val = CNT_W'(GUARD_CYCLES - 1);
      ENABLE:  tmr_val = CNT_W'(SETTLE_CYCLES - 1);
      default: tmr_val = '0;
    endcase
  end

  io_seq_timer #(.W(CNT_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .val_i     (tmr_val),
    .expired_o (tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      active_q <= '0;
      dis_q    <= '0;
      ena_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      dis_q    <= dis_d;
      ena_q    <= ena_d;
      tmo_q    <= tmo_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign busy         = ~req_ready;
  assign done         = (state_q == DONE);
  assign done_timeout = tmo_q;
  assign active_mask  = active_q;
  assign irq_en       = active_q[FN_IRQ];
  assign uart_en      = active_q[FN_UART1 +: N_UART];
  assign spi_en       = active_q[FN_SPI0 +: 1];
  assign pwm_en       = active_q[FN_PWM0 +: N_PWM];

endmodule

// File: tb/tb_io_function_sequencer.sv
// Scoreboard bench: each accepted request pushes its expected final mask,
// timeout flag and done cycle; a monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_io_function_sequencer;

  localparam int GUARD  = 4;
  localparam int SETTLE = 2;
  localparam int TMO    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [12:0] req_mask = '0;
  logic [12:0] periph_idle = '1;
  logic [12:0] active_mask;
  logic        irq_en;
  logic [2:0]  uart_en;
  logic [0:0]  spi_en;
  logic [7:0]  pwm_en;
  logic        busy, done, done_timeout;

  io_function_sequencer #(
    .GUARD_CYCLES(GUARD), .SETTLE_CYCLES(SETTLE), .IDLE_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_mask(req_mask), .periph_idle(periph_idle), .active_mask(active_mask),
    .irq_en(irq_en), .uart_en(uart_en), .spi_en(spi_en), .pwm_en(pwm_en),
    .busy(busy), .done(done), .done_timeout(done_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] mask;
    logic        tmo;
    int          done_at;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_chk = 0, n_pass = 0;
  int          n_acc = 0, n_done = 0, n_spur = 0, ov_cnt = 0;
  logic [12:0] m_act = '0;
  logic [12:0] cur_dis = '0, cur_ena = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: compare on done, and watch for any cycle holding both a
  // disabled and an enabled function of the current transaction.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (q.size() == 0) n_spur++;
        else begin
          exp_t e;
          e = q.pop_front();
          n_done++;
          chk("done_pins", {19'd0, pwm_en, spi_en, uart_en, irq_en}, {19'd0, e.mask});
          chk("done_active", {19'd0, active_mask}, {19'd0, e.mask});
          chk("done_timeout", {31'd0, done_timeout}, {31'd0, e.tmo});
          chk("done_cycle", cyc, e.done_at);
          chk("done_busy", {31'd0, busy}, 32'd1);
        end
      end
      if (((active_mask & cur_dis) != 0) && ((active_mask & cur_ena) != 0)) ov_cnt++;
    end
  end

  function automatic int exp_k(input logic [12:0] act, input logic [12:0] req,
                               input logic [12:0] idle);
    logic [12:0] d, en;
    int qd;
    d  = act & ~req;
    en = req & ~act;
    if (d != 0) begin
      qd = ((idle & d) == d) ? 1 : TMO;
      return qd + GUARD + ((en != 0) ? SETTLE : 0) + 1;
    end
    if (en != 0) return SETTLE + 1;
    return 1;
  endfunction

  // Returns at accept edge + #1 (cycle 1) when hold == 0.
  task automatic issue(input logic [12:0] mask, input int k, input logic tmo, input int hold);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 100) begin @(negedge clk); w++; end
    if (!req_ready) chk("ready_wait", {31'd0, req_ready}, 32'd1);
    cur_dis   = m_act & ~mask;
    cur_ena   = mask & ~m_act;
    req_valid = 1'b1;
    req_mask  = mask;
    @(posedge clk); #1;
    q.push_back('{mask, tmo, cyc + k - 1});
    n_acc++;
    m_act = mask;
    if (hold > 0) begin
      req_mask = ~mask;
      repeat (hold) @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (q.size() != 0 && w < 200) begin @(negedge clk); w++; end
    chk("done_wait", q.size(), 0);
    q.delete();
    @(negedge clk);
    chk("ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [12:0] m, idl;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_active", {19'd0, active_mask}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {30'd0, done, done_timeout}, 32'd0);

    // T2 enable-only
    issue(13'h002, 3, 1'b0, 0);
    chk("t2_uart_c1", {29'd0, uart_en}, 32'h1);
    wait_done();

    // T1 reset during DISABLE
    cur_dis = 13'h002; cur_ena = '0;
    @(negedge clk); req_valid = 1'b1; req_mask = '0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    chk("t1_dis_active", {19'd0, active_mask}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t1_rst_active", {19'd0, active_mask}, 32'd0);
    chk("t1_rst_ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0; m_act = '0;
    // reset during QUIESCE drops a still-applied mask
    issue(13'h002, 3, 1'b0, 0);
    wait_done();
    periph_idle = '0;
    cur_dis = 13'h002; cur_ena = '0;
    @(negedge clk); req_valid = 1'b1; req_mask = '0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    chk("t1_quiesce_active", {19'd0, active_mask}, 32'h002);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t1_q_rst_active", {19'd0, active_mask}, 32'd0);
    chk("t1_q_rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0; m_act = '0; periph_idle = '1;

    // T3 swap SPI -> UART1..3
    issue(13'h010, 3, 1'b0, 0);
    wait_done();
    issue(13'h00E, 8, 1'b0, 0);
    chk("t3_spi_c1", {31'd0, spi_en}, 32'd1);
    @(posedge clk); #1;
    chk("t3_spi_c2", {31'd0, spi_en}, 32'd0);
    chk("t3_uart_c2", {29'd0, uart_en}, 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("t3_uart_c5", {29'd0, uart_en}, 32'd0);
    @(posedge clk); #1;
    chk("t3_uart_c6", {29'd0, uart_en}, 32'h7);
    wait_done();

    // T4 quiesce timeout
    issue(13'h1E0, 8, 1'b0, 0);
    wait_done();
    periph_idle = '0;
    issue(13'h000, TMO + GUARD + 1, 1'b1, 0);
    repeat (15) @(posedge clk); #1;
    chk("t4_pwm_c16", {24'd0, pwm_en}, 32'h0F);
    @(posedge clk); #1;
    chk("t4_pwm_c17", {24'd0, pwm_en}, 32'h00);
    wait_done();
    periph_idle = '1;

    // T5 no-op, valid held while busy
    issue(13'h0A5, 3, 1'b0, 0);
    wait_done();
    issue(13'h0A5, 1, 1'b0, 1);
    wait_done();
    chk("t5_active", {19'd0, active_mask}, 32'h0A5);
    issue(13'h000, 1 + GUARD + 1, 1'b0, 5);
    wait_done();
    repeat (3) @(negedge clk);
    chk("t5_no_reaccept", n_done, n_acc);

    // T6 random masks and idle patterns
    for (int i = 0; i < 1000; i++) begin
      r = $urandom(); m = r[12:0];
      r = $urandom();
      case ($urandom_range(0, 2))
        0:       idl = '1;
        1:       idl = r[12:0];
        default: idl = '0;
      endcase
      periph_idle = idl;
      issue(m, exp_k(m_act, m, idl), ((m_act & ~m) != 0) && ((idl & m_act & ~m) != (m_act & ~m)), 0);
      wait_done();
    end
    chk("t6_final_active", {19'd0, active_mask}, {19'd0, m_act});

    chk("spurious_done", n_spur, 0);
    chk("overlap", ov_cnt, 0);
    chk("done_per_accept", n_done, n_acc);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
